// File: rtl/mrd_fsm_pkg.sv
// Shared state codes and limits for the mixed-radix DFT stage sequencer.
// The read-address generator and the write-back path import this package.
package mrd_fsm_pkg;

  localparam int MAX_STAGES_DEF = 6;
  localparam int WDOG_W         = 12;
  localparam int WAIT_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SINK        = 3'd1,
    ST_WAIT_TO_RD  = 3'd2,
    ST_RD          = 3'd3,
    ST_WAIT_WR_END = 3'd4,
    ST_SOURCE      = 3'd5
  } state_t;

  function automatic logic nf_legal(input logic [2:0] nf, input logic [2:0] max_nf);
    return (nf != 3'd0) && (nf <= max_nf);
  endfunction

endpackage

// File: rtl/mrd_stage_sequencer_if.sv
// Trigger and status bundle between the stage sequencer and its neighbours.
interface mrd_stage_sequencer_if;

  // Every trigger (start and the *_end signals) is a single-cycle pulse sampled
  // on the rising clock edge; there is no back-pressure, so a pulse that is not
  // legal in the current state is dropped and recorded in err.
  logic       start;
  logic [2:0] num_factors;
  logic       sink_end;
  logic       rd_end;
  logic       wr_end;
  logic       source_end;

  logic [2:0] fsm;
  logic [2:0] fsm_r;
  logic [2:0] cnt_stage;
  logic       sink_ready;
  logic       busy;
  logic       frame_done;
  logic       err;

  modport master (
    output start, num_factors, sink_end, rd_end, wr_end, source_end,
    input  fsm, fsm_r, cnt_stage, sink_ready, busy, frame_done, err
  );

  modport slave (
    input  start, num_factors, sink_end, rd_end, wr_end, source_end,
    output fsm, fsm_r, cnt_stage, sink_ready, busy, frame_done, err
  );

endinterface

// File: rtl/mrd_stage_watchdog.sv
// 12-bit cycle counter for the Wait_wr_end timeout; expire is high during the
// LIMIT-th enabled cycle after a clear.
module mrd_stage_watchdog
  import mrd_fsm_pkg::*;
#(
  parameter logic [WDOG_W-1:0] LIMIT = 12'd4095
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  assign expire = en && !clr && (cnt_q == LIMIT - 12'd1);

  // Saturate at expiry so a held enable never wraps into a second timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mrd_stage_sequencer.sv
// Frame sequencer: Sink, then Wait_to_rd/Rd/Wait_wr_end per radix stage, then
// Source; out-of-order trigger pulses set a sticky err flag.
module mrd_stage_sequencer
  import mrd_fsm_pkg::*;
#(
  parameter int unsigned       WAIT_TO_RD = 4,
  parameter int unsigned       MAX_STAGES = MAX_STAGES_DEF,
  parameter logic [WDOG_W-1:0] WDOG_CYC   = 12'd4095
) (
  input logic                  clk,
  input logic                  rst,
  mrd_stage_sequencer_if.slave bus
);

  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_TO_RD[WAIT_W-1:0];
  localparam logic [2:0]        MAX_NF   = MAX_STAGES[2:0];

  state_t              state_q, state_d;
  logic [2:0]          fsm_r_q, fsm_r_d;
  logic [2:0]          cnt_stage_q, cnt_stage_d;
  logic [2:0]          nf_lat_q, nf_lat_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                err_q, err_d;
  logic                wdog_expire;

  mrd_stage_watchdog #(.LIMIT(WDOG_CYC)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != ST_WAIT_WR_END),
    .en     (state_q == ST_WAIT_WR_END),
    .expire (wdog_expire)
  );

  always_comb begin
    state_d      = state_q;
    fsm_r_d      = state_q;
    cnt_stage_d  = cnt_stage_q;
    nf_lat_d     = nf_lat_q;
    wait_cnt_d   = wait_cnt_q;
    frame_done_d = 1'b0;
    err_d        = err_q;

    // Stray pulses are flagged here; the case below only acts on legal ones.
    if (bus.start      && state_q != ST_IDLE)        err_d = 1'b1;
    if (bus.sink_end   && state_q != ST_SINK)        err_d = 1'b1;
    if (bus.rd_end     && state_q != ST_RD)          err_d = 1'b1;
    if (bus.wr_end     && state_q != ST_WAIT_WR_END) err_d = 1'b1;
    if (bus.source_end && state_q != ST_SOURCE)      err_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (nf_legal(bus.num_factors, MAX_NF)) begin
            state_d  = ST_SINK;
            nf_lat_d = bus.num_factors;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SINK: begin
        if (bus.sink_end) begin
          state_d     = ST_WAIT_TO_RD;
          cnt_stage_d = 3'd0;
          wait_cnt_d  = 4'd1;
        end
      end
      ST_WAIT_TO_RD: begin
        if (wait_cnt_q == WAIT_LIM) begin
          state_d = ST_RD;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_RD: begin
        if (bus.rd_end) state_d = ST_WAIT_WR_END;
      end
      ST_WAIT_WR_END: begin
        // wr_end takes priority over a watchdog expiry in the same cycle.
        if (bus.wr_end) begin
          if (cnt_stage_q == nf_lat_q - 3'd1) begin
            state_d = ST_SOURCE;
          end else begin
            state_d     = ST_WAIT_TO_RD;
            cnt_stage_d = cnt_stage_q + 3'd1;
            wait_cnt_d  = 4'd1;
          end
        end else if (wdog_expire) begin
          state_d     = ST_IDLE;
          cnt_stage_d = 3'd0;
          err_d       = 1'b1;
        end
      end
      ST_SOURCE: begin
        if (bus.source_end) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fsm_r_q      <= 3'd0;
      cnt_stage_q  <= 3'd0;
      nf_lat_q     <= 3'd0;
      wait_cnt_q   <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fsm_r_q      <= fsm_r_d;
      cnt_stage_q  <= cnt_stage_d;
      nf_lat_q     <= nf_lat_d;
      wait_cnt_q   <= wait_cnt_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.fsm        = state_q;
  assign bus.fsm_r      = fsm_r_q;
  assign bus.cnt_stage  = cnt_stage_q;
  assign bus.sink_ready = (state_q == ST_SINK);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mrd_stage_sequencer.sv
// Bench for mrd_stage_sequencer: builds per-cycle stimulus and expected output
// traces from phase durations, then replays them in lockstep against the DUT.
module tb_mrd_stage_sequencer;

  localparam int WAIT_TO_RD = 4;
  localparam int MAX_STAGES = 6;
  localparam int WDOG_CYC   = 4095;
  localparam int SW = 9;   // {rst, start, nf[2:0], sink_end, rd_end, wr_end, source_end}
  localparam int EW = 11;  // {fsm, fsm_r, cnt_stage, frame_done, err}

  localparam logic [SW-1:0] P_NONE  = 9'b0_0000_0000;
  localparam logic [SW-1:0] P_SRC   = 9'b0_0000_0001;
  localparam logic [SW-1:0] P_WR    = 9'b0_0000_0010;
  localparam logic [SW-1:0] P_RD    = 9'b0_0000_0100;
  localparam logic [SW-1:0] P_SINK  = 9'b0_0000_1000;
  localparam logic [SW-1:0] P_START = 9'b0_1000_0000;
  localparam logic [SW-1:0] P_RST   = 9'b1_0000_0000;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mrd_stage_sequencer_if bus ();

  mrd_stage_sequencer #(
    .WAIT_TO_RD (WAIT_TO_RD),
    .MAX_STAGES (MAX_STAGES),
    .WDOG_CYC   (12'(WDOG_CYC))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard
  logic [SW-1:0] stim_q[$];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model: expected stage index, sticky error, last fsm code
  int m_cnt  = 0;
  int m_err  = 0;
  int m_last = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] start_p(input int nf);
    logic [SW-1:0] s;
    s = P_START;
    s[6:4] = 3'(nf);
    return s;
  endfunction

  // One cycle: pulses s applied before the edge, outputs expected after it.
  task automatic push(input logic [SW-1:0] s, input int fsm, input int fd);
    logic [2:0] r;
    r = s[8] ? 3'd0 : 3'(m_last);
    stim_q.push_back(s);
    exp_q.push_back({3'(fsm), r, 3'(m_cnt), 1'(fd), 1'(m_err)});
    m_last = fsm;
  endtask

  task automatic do_rst();
    logic [SW-1:0] s;
    m_cnt = 0;
    m_err = 0;
    s = P_RST | SW'($urandom_range(0, 255));
    push(s, 0, 0);
  endtask

  // A pulse that is illegal in the given phase, or nothing if the pick is legal.
  function automatic logic [SW-1:0] stray(input int phase);
    int k;
    k = int'($urandom_range(0, 4));
    case (k)
      0: return (phase != 0) ? start_p(int'($urandom_range(0, 7))) : P_NONE;
      1: return (phase != 1) ? P_SINK : P_NONE;
      2: return (phase != 3) ? P_RD : P_NONE;
      3: return (phase != 4) ? P_WR : P_NONE;
      default: return (phase != 5) ? P_SRC : P_NONE;
    endcase
  endfunction

  // n cycles in which the phase does not change; strays optionally injected.
  task automatic gap(input int phase, input int n, input bit strays);
    logic [SW-1:0] s;
    for (int i = 0; i < n; i++) begin
      s = P_NONE;
      if (strays && $urandom_range(0, 3) == 0) s = stray(phase);
      if (s != P_NONE) m_err = 1;
      push(s, phase, 0);
    end
  endtask

  // Whole frame. stall_stage: stage whose wr_end never comes; abort_stage:
  // stage whose Rd is interrupted by rst. -1 disables either.
  task automatic frame(input int nf, input int sink_gap, input int rd_gap, input int wr_gap,
                       input int src_gap, input bit strays, input int stall_stage,
                       input int abort_stage);
    push(start_p(nf), 1, 0);
    gap(1, sink_gap, strays);
    m_cnt = 0;
    push(P_SINK, 2, 0);
    for (int st = 0; st < nf; st++) begin
      gap(2, WAIT_TO_RD - 1, strays);
      push(P_NONE, 3, 0);
      if (st == abort_stage) begin
        gap(3, 2, 1'b0);
        do_rst();
        return;
      end
      gap(3, rd_gap, strays);
      push(P_RD, 4, 0);
      if (st == stall_stage) begin
        gap(4, WDOG_CYC - 1, 1'b0);
        m_cnt = 0;
        m_err = 1;
        push(P_NONE, 0, 0);
        return;
      end
      gap(4, wr_gap, strays);
      if (st == nf - 1) begin
        push(P_WR, 5, 0);
      end else begin
        m_cnt = st + 1;
        push(P_WR, 2, 0);
      end
    end
    gap(5, src_gap, strays);
    push(P_SRC, 0, 1);
  endtask

  task automatic build();
    do_rst();
    push(P_NONE, 0, 0);

    // nominal 3-stage frame, wr_end 10 cycles after rd_end
    frame(3, 2, 3, 9, 2, 1'b0, -1, -1);
    push(P_NONE, 0, 0);

    // random clean frames, sometimes back-to-back after frame_done
    for (int i = 0; i < 10; i++) begin
      frame(int'($urandom_range(1, MAX_STAGES)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 6)), int'($urandom_range(0, 20)),
            int'($urandom_range(0, 5)), 1'b0, -1, -1);
      if ($urandom_range(0, 1) == 1) push(P_NONE, 0, 0);
    end

    // illegal num_factors, then a single-stage frame
    m_err = 1;
    push(start_p(0), 0, 0);
    push(P_NONE, 0, 0);
    push(start_p(7), 0, 0);
    do_rst();
    frame(1, 1, 1, 1, 1, 1'b0, -1, -1);

    // directed strays: rd_end in Sink, wr_end in Rd, start in Source
    do_rst();
    push(start_p(2), 1, 0);
    m_err = 1;
    push(P_RD, 1, 0);
    m_cnt = 0;
    push(P_SINK, 2, 0);
    gap(2, WAIT_TO_RD - 1, 1'b0);
    push(P_NONE, 3, 0);
    push(P_WR, 3, 0);
    push(P_RD, 4, 0);
    m_cnt = 1;
    push(P_WR, 2, 0);
    gap(2, WAIT_TO_RD - 1, 1'b0);
    push(P_NONE, 3, 0);
    push(P_RD, 4, 0);
    push(P_WR, 5, 0);
    push(start_p(1), 5, 0);
    push(P_SRC, 0, 1);

    // random strays
    for (int i = 0; i < 4; i++) begin
      do_rst();
      frame(int'($urandom_range(1, MAX_STAGES)), int'($urandom_range(1, 5)),
            int'($urandom_range(1, 6)), int'($urandom_range(1, 12)),
            int'($urandom_range(1, 5)), 1'b1, -1, -1);
    end

    // rd_end and wr_end together in Rd
    do_rst();
    push(start_p(1), 1, 0);
    m_cnt = 0;
    push(P_SINK, 2, 0);
    gap(2, WAIT_TO_RD - 1, 1'b0);
    push(P_NONE, 3, 0);
    m_err = 1;
    push(P_RD | P_WR, 4, 0);
    gap(4, 3, 1'b0);
    push(P_WR, 5, 0);
    push(P_SRC, 0, 1);

    // reset during Rd of stage 1, then a clean frame
    do_rst();
    frame(3, 1, 2, 4, 1, 1'b0, -1, 1);
    frame(2, 1, 1, 2, 1, 1'b0, -1, -1);

    // watchdog expiry, then wr_end on the expiry cycle
    do_rst();
    frame(2, 1, 1, 0, 0, 1'b0, 0, -1);
    push(P_NONE, 0, 0);
    do_rst();
    frame(1, 1, 1, WDOG_CYC - 1, 1, 1'b0, -1, -1);
    push(P_NONE, 0, 0);
  endtask

  // driver + lockstep compare
  initial begin
    logic [SW-1:0] s;
    logic [EW-1:0] e;
    bus.start       = 1'b0;
    bus.num_factors = 3'd0;
    bus.sink_end    = 1'b0;
    bus.rd_end      = 1'b0;
    bus.wr_end      = 1'b0;
    bus.source_end  = 1'b0;
    build();
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      rst             = s[8];
      bus.start       = s[7];
      bus.num_factors = s[6:4];
      bus.sink_end    = s[3];
      bus.rd_end      = s[2];
      bus.wr_end      = s[1];
      bus.source_end  = s[0];
      @(posedge clk);
      #1;
      cyc++;
      check_eq("fsm",        32'(bus.fsm),        32'(e[10:8]));
      check_eq("fsm_r",      32'(bus.fsm_r),      32'(e[7:5]));
      check_eq("cnt_stage",  32'(bus.cnt_stage),  32'(e[4:2]));
      check_eq("frame_done", 32'(bus.frame_done), 32'(e[1]));
      check_eq("err",        32'(bus.err),        32'(e[0]));
      check_eq("busy",       32'(bus.busy),       32'(e[10:8] != 3'd0));
      check_eq("sink_ready", 32'(bus.sink_ready), 32'(e[10:8] == 3'd1));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
